// File: rtl/auth_display_ctrl_pkg.sv
// Shared constants for the auth display path.
// Holds the seven-segment glyph codes (used with shift=1), the blank code
// for the numeric field, and the display sequencer state encoding. The
// decoder tests import the same constants, so codes are defined only here.
package auth_disp_pkg;

  localparam logic [3:0] GLY_BLANK = 4'b0000;
  localparam logic [3:0] GLY_1     = 4'b0001;
  localparam logic [3:0] GLY_2     = 4'b0010;
  localparam logic [3:0] GLY_3     = 4'b0011;
  localparam logic [3:0] GLY_E     = 4'b0101;
  localparam logic [3:0] GLY_L     = 4'b0110;
  localparam logic [3:0] GLY_U     = 4'b0111;
  localparam logic [3:0] GLY_DASH  = 4'b1000;
  localparam logic [3:0] GLY_A     = 4'b1111;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    PASS   = 3'd2,
    FAIL   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  // Attempts-left count as a glyph; zero tries shows as blank.
  function automatic logic [3:0] att_glyph(input logic [1:0] att);
    case (att)
      2'd1:    return GLY_1;
      2'd2:    return GLY_2;
      2'd3:    return GLY_3;
      default: return GLY_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/auth_display_ctrl_if.sv
// Bundle between the keypad/authenticator side and the display sequencer.
// master: keypad/authenticator (drives events, observes the display code)
// slave : auth_display_ctrl (consumes events, drives bcd1/bcd2/shift)
// Handshake: there is no back-pressure. digit_valid, auth_pass and
// auth_fail are single-cycle strobes sampled on the rising clock edge and
// are never held or acknowledged; locked is a level; attempts_left is
// sampled on the edge where a strobe uses it. bcd1/bcd2/shift are always
// valid and change only on clock edges.
interface auth_display_ctrl_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       auth_pass;
  logic       auth_fail;
  logic [1:0] attempts_left;
  logic       locked;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic       shift;

  modport master (
    output digit_valid, digit, auth_pass, auth_fail, attempts_left, locked,
    input  bcd1, bcd2, shift
  );

  modport slave (
    input  digit_valid, digit, auth_pass, auth_fail, attempts_left, locked,
    output bcd1, bcd2, shift
  );
endinterface

// File: rtl/auth_display_ctrl_timer.sv
// disp_timer: up-counter with synchronous clear and terminal count.
// Ports: clk, rst_n (async active-low), clr (restart at 0, wins over en),
// en (count), target (terminal count value), tc (high on the enabled cycle
// where the count sits at target; the counter wraps to 0 on that edge).
module disp_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] target,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // >= rather than == so a stale count above a smaller target still wraps.
  assign tc = en && (cnt >= target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt >= target) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/auth_display_ctrl.sv
// auth_display_ctrl: display sequencer feeding the two-digit 7-seg decoder.
// Ports: clk, rst_n (async active-low), bus (slave side of
// auth_display_ctrl_if: keypad/auth events in, bcd1/bcd2/shift out),
// state_dbg (current sequencer state).
// All display fields are registered, so an event shows one cycle later.
module auth_display_ctrl
  import auth_disp_pkg::*;
#(
  parameter int HOLD_CYCLES  = 10_000_000,
  parameter int BLINK_CYCLES = 5_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  auth_display_ctrl_if.slave        bus,
  output state_t                    state_dbg
);

  localparam int MAX_CYC = (HOLD_CYCLES > BLINK_CYCLES) ? HOLD_CYCLES : BLINK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_TGT  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_TGT = CNT_W'(BLINK_CYCLES - 1);

  state_t     state;
  logic [3:0] bcd1_q, bcd2_q;
  logic       shift_q;

  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_tgt;

  // The timer restarts on entry to LOCKED and on every accepted result
  // strobe (which also restarts an ongoing hold).
  always_comb begin
    tmr_clr = 1'b0;
    if (bus.locked) tmr_clr = (state != LOCKED);
    else if (state != LOCKED) tmr_clr = bus.auth_pass || bus.auth_fail;
    tmr_en  = (state == PASS) || (state == FAIL) || (state == LOCKED);
    tmr_tgt = (state == LOCKED) ? BLINK_TGT : HOLD_TGT;
  end

  disp_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .target (tmr_tgt),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd1_q  <= BCD_BLANK;
      bcd2_q  <= GLY_DASH;
      shift_q <= 1'b1;
    end else begin
      shift_q <= 1'b1;
      if (bus.locked) begin
        bcd1_q <= BCD_BLANK;
        if (state != LOCKED) begin
          state  <= LOCKED;
          bcd2_q <= GLY_L;
        end else if (tmr_tc) begin
          bcd2_q <= (bcd2_q == GLY_L) ? GLY_BLANK : GLY_L;
        end
      end else if (state == LOCKED) begin
        state  <= IDLE;
        bcd1_q <= BCD_BLANK;
        bcd2_q <= GLY_DASH;
      end else if (bus.auth_pass) begin
        state  <= PASS;
        bcd1_q <= BCD_BLANK;
        bcd2_q <= GLY_U;
      end else if (bus.auth_fail) begin
        state  <= FAIL;
        bcd1_q <= {2'b00, bus.attempts_left};
        bcd2_q <= GLY_E;
      end else if (bus.digit_valid && (bus.digit <= 4'd9) &&
                   ((state == IDLE) || (state == ENTRY))) begin
        state  <= ENTRY;
        bcd1_q <= bus.digit;
        bcd2_q <= att_glyph(bus.attempts_left);
      end else if (((state == PASS) || (state == FAIL)) && tmr_tc) begin
        state  <= IDLE;
        bcd1_q <= BCD_BLANK;
        bcd2_q <= GLY_DASH;
      end
    end
  end

  assign bus.bcd1  = bcd1_q;
  assign bus.bcd2  = bcd2_q;
  assign bus.shift = shift_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_auth_display_ctrl.sv
module tb_auth_display_ctrl;
  import auth_disp_pkg::*;

  localparam int HOLD  = 8;
  localparam int BLINK = 4;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_PASS = 2, M_FAIL = 3, M_LOCK = 4;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  always #5 clk = ~clk;

  auth_display_ctrl_if bus();

  auth_display_ctrl #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  string      phase   = "reset";

  // Reference model: display content derived from mode plus absolute cycle
  // stamps of the last result and of lockout entry.
  int     mode       = M_IDLE;
  int     last_digit = 0;
  int     entry_att  = 0;
  int     res_att    = 0;
  longint cyc        = 0;
  longint hold_start = 0;
  longint lock_start = 0;

  function automatic logic [8:0] model_disp();
    logic [3:0] b1, b2;
    case (mode)
      M_ENTRY: begin b1 = 4'(last_digit); b2 = (entry_att == 0) ? 4'h0 : 4'(entry_att); end
      M_PASS:  begin b1 = 4'hF; b2 = 4'h7; end
      M_FAIL:  begin b1 = 4'(res_att); b2 = 4'h5; end
      M_LOCK:  begin b1 = 4'hF; b2 = (((cyc - lock_start) / BLINK) % 2 == 0) ? 4'h6 : 4'h0; end
      default: begin b1 = 4'hF; b2 = 4'h8; end
    endcase
    return {b1, b2, 1'b1};
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    mode = M_IDLE;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mode = M_IDLE;
    end else if (bus.locked) begin
      if (mode != M_LOCK) begin mode = M_LOCK; lock_start = cyc; end
    end else if (mode == M_LOCK) begin
      mode = M_IDLE;
    end else if (bus.auth_pass) begin
      mode = M_PASS; hold_start = cyc;
    end else if (bus.auth_fail) begin
      mode = M_FAIL; hold_start = cyc; res_att = int'(bus.attempts_left);
    end else if (bus.digit_valid && bus.digit <= 9 && (mode == M_IDLE || mode == M_ENTRY)) begin
      mode = M_ENTRY; last_digit = int'(bus.digit); entry_att = int'(bus.attempts_left);
    end else if ((mode == M_PASS || mode == M_FAIL) && (cyc - hold_start >= HOLD)) begin
      mode = M_IDLE;
    end
    exp_q.push_back(model_disp());
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.bcd1, bus.bcd2, bus.shift} !== e) begin
        n_fail++;
        $display("FAIL %s t=%0t: got bcd1=%h bcd2=%b shift=%b, expected bcd1=%h bcd2=%b shift=%b",
                 phase, $time, bus.bcd1, bus.bcd2, bus.shift, e[8:5], e[4:1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [1:0] cur_att = 2'd3;
  logic       cur_lk  = 1'b0;

  task automatic step(input logic dv, input logic [3:0] d, input logic p, input logic f);
    @(negedge clk);
    bus.digit_valid   = dv;
    bus.digit         = d;
    bus.auth_pass     = p;
    bus.auth_fail     = f;
    bus.attempts_left = cur_att;
    bus.locked        = cur_lk;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must return before the next edge.
  task automatic async_reset(input string name);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.bcd1, bus.bcd2, bus.shift} !== {4'hF, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL %s: got bcd1=%h bcd2=%b shift=%b, expected bcd1=f bcd2=1000 shift=1",
               name, bus.bcd1, bus.bcd2, bus.shift);
    end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.digit_valid = 1'b0; bus.digit = 4'd0; bus.auth_pass = 1'b0;
    bus.auth_fail = 1'b0; bus.attempts_left = 2'd3; bus.locked = 1'b0;
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    idle(3);

    phase = "digit_entry";
    cur_att = 2'd3;
    step(1'b1, 4'd7, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 4'd12, 1'b0, 1'b0);
    idle(2);
    cur_att = 2'd0;
    step(1'b1, 4'd9, 1'b0, 1'b0);
    idle(2);

    phase = "async_reset_entry";
    async_reset(phase);
    idle(2);

    phase = "fail_hold";
    cur_att = 2'd2;
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    idle(10);

    phase = "pass_restart";
    step(1'b0, 4'd0, 1'b1, 1'b1);
    idle(4);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(12);

    phase = "locked_blink";
    cur_lk = 1'b1;
    idle(5);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b1);
    idle(12);
    cur_lk = 1'b0;
    idle(3);

    phase = "reset_in_lock";
    cur_lk = 1'b1;
    idle(6);
    cur_lk = 1'b0;
    async_reset(phase);
    idle(3);
    phase = "relock";
    cur_lk = 1'b1;
    idle(6);
    cur_lk = 1'b0;
    idle(2);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      logic p, f, dv;
      if ($urandom_range(0, 39) == 0) cur_lk = ~cur_lk;
      p  = ($urandom_range(0, 19) == 0);
      f  = ($urandom_range(0, 14) == 0);
      dv = ($urandom_range(0, 3) == 0);
      // attempts_left only moves on result strobes so it is always the
      // value the display should latch.
      if (p || f) cur_att = 2'($urandom_range(0, 3));
      step(dv, 4'($urandom_range(0, 15)), p, f);
    end
    cur_lk = 1'b0;
    idle(HOLD + 4);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
